rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter ADDR_W, default 4; instruction memory address width; depth is 2^ADDR_W words.
REQ-002 clock  input  1  sole clock; all state changes on posedge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a load; honoured only in IDLE.
REQ-005 length  input  ADDR_W+1  number of 16-bit words to load, 0..2^ADDR_W; sampled on the accepted start.
REQ-006 in_data  input  8  byte stream carrying program words.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  loader can accept a byte this cycle.
REQ-009 wr_address  output  ADDR_W  instruction memory write address.
REQ-010 wr_data  output  16  instruction word to write.
REQ-011 wr_en  output  1  write strobe, one cycle per word.
REQ-012 cpu_hold  output  1  holds the CPU in reset while a load is in progress.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  single-cycle pulse on load completion.
REQ-015 error  output  1  checksum mismatch flag; sticky until the next accepted start.

Function
REQ-016 The state machine SHALL have states IDLE, HI, LO, WRITE, CHK_HI, CHK_LO and DONE.
- CHK_HI and CHK_LO exist only with the configuration macro (REQ-029).
REQ-017 In IDLE, start with length>0 SHALL latch length, clear the word counter and error, and go to HI.
REQ-018 In IDLE, start with length=0 SHALL go directly to DONE with no writes.
REQ-019 A byte transfer SHALL occur only on a cycle with in_valid && in_ready.
- in_ready is high only in HI, LO, CHK_HI and CHK_LO.
REQ-020 Byte order SHALL be big-endian.
- The byte taken in HI forms bits 15:8; the byte taken in LO forms bits 7:0.
- Each transfer advances HI to LO, and LO to WRITE.
REQ-021 In WRITE, the block SHALL drive wr_en=1, wr_address=word counter and wr_data=assembled word for exactly one cycle.
- wr_en therefore asserts on the cycle after the low byte is accepted.
REQ-022 After WRITE, the counter SHALL increment. If counter+1 equals length, the next state is DONE (or CHK_HI when checksum is enabled); otherwise it is HI.
REQ-023 length=2^ADDR_W SHALL write addresses 0..2^ADDR_W-1 exactly once.
- The counter is ADDR_W+1 bits wide; wr_address never wraps to 0 within a load.
REQ-024 DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-025 cpu_hold SHALL equal busy.
- done and cpu_hold fall on the same edge.
REQ-026 start outside IDLE SHALL be ignored.
- in_valid outside the byte-accepting states SHALL be ignored, with no byte consumed.

Reset
REQ-027 On reset assertion, all outputs SHALL go to 0 immediately (asynchronously), and the FSM SHALL go to IDLE.
- A load interrupted by reset is abandoned; words already written are not rewritten.
REQ-028 After reset deassertion, the first start SHALL begin a fresh load from address 0.

Configuration
REQ-029 With ROM_LOADER_CHECKSUM_EN defined, the block SHALL keep a 16-bit modulo sum of all written words.
- After the last WRITE it reads a big-endian checksum word in CHK_HI/CHK_LO, then enters DONE.
- error is set in the same cycle as done if the checksum differs from the sum.
- The checksum states are not entered when length=0.
REQ-030 Without ROM_LOADER_CHECKSUM_EN, the CHK states, the sum register and the extra bytes SHALL be absent, and error SHALL be tied to 0.

Structure
REQ-031 The shared package hack_mem_pkg SHALL hold the state enum and the constant INSTR_W=16.
REQ-032 The byte-to-word assembly (high/low byte registers and the assembled output) SHALL be a sub-module named word_assembler.
- All control stays in rom_loader.

Verification
REQ-033 Load of length=6 with bytes EA 90 E3 20 EE 88 E7 D0 00 01 EA 87, in_valid always high:
- writes at addresses 0..5 with 0xEA90, 0xE320, 0xEE88, 0xE7D0, 0x0001, 0xEA87;
- each wr_en is one cycle; done pulses once; cpu_hold is high throughout.
REQ-034 Same load with in_valid toggling every other cycle: identical writes; no byte dropped or duplicated.
REQ-035 start with length=0: done pulses on the cycle after start; wr_en never asserts; in_ready stays 0.
REQ-036 length=16 with ADDR_W=4: 16 writes at addresses 0..15 in order; no write to address 0 after address 15; then done.
REQ-037 Reset asserted after 3 words, then a new start with length=2:
- all outputs go to 0 without waiting for a clock edge;
- the new load writes addresses 0 and 1 only.
REQ-038 With ROM_LOADER_CHECKSUM_EN, length=2 with words 0x0001 and 0x0002:
- checksum 0x0003: done pulses with error=0;
- checksum 0x0004: done pulses with error=1, and error holds until the next start.

Source files
------------

// File: rtl/hack_mem_pkg.sv
// Shared types and constants for the ROM loader slice.
// The checksum states exist only when ROM_LOADER_CHECKSUM_EN is defined.
package hack_mem_pkg;

   localparam int INSTR_W = 16;
   localparam int BYTE_W  = 8;

`ifdef ROM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE, S_HI, S_LO, S_WRITE, S_CHK_HI, S_CHK_LO, S_DONE
   } state_e;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_HI, S_LO, S_WRITE, S_DONE
   } state_e;
`endif

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word assembly: high byte register, low byte register
// and the concatenated instruction word.
module word_assembler
   import hack_mem_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic [BYTE_W-1:0]  in_data,
   input  logic               hi_load,
   input  logic               lo_load,
   output logic [INSTR_W-1:0] word
);

   logic [BYTE_W-1:0] hi_q, hi_d;
   logic [BYTE_W-1:0] lo_q, lo_d;

   always_comb begin
      hi_d = hi_load ? in_data : hi_q;
      lo_d = lo_load ? in_data : lo_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign word = {hi_q, lo_q};

endmodule

// File: rtl/rom_loader.sv
// Loads big-endian 16-bit program words from a byte stream into instruction
// memory while holding the CPU. ROM_LOADER_CHECKSUM_EN adds a trailing checksum.
module rom_loader
   import hack_mem_pkg::*;
#(
   parameter int ADDR_W = 4
)
(
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_W:0]    length,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [ADDR_W-1:0]  wr_address,
   output logic [15:0]        wr_data,
   output logic               wr_en,
   output logic               cpu_hold,
   output logic               busy,
   output logic               done,
   output logic               error
);

   state_e             state_q, state_d;
   logic [ADDR_W:0]    cnt_q, cnt_d;
   logic [ADDR_W:0]    len_q, len_d;
   logic [ADDR_W:0]    cnt_inc;
   logic [INSTR_W-1:0] asm_word;
   logic               hi_load, lo_load;
   logic               xfer;

`ifdef ROM_LOADER_CHECKSUM_EN
   logic [INSTR_W-1:0] sum_q, sum_d;
   logic               error_q, error_d;
`endif

   assign xfer    = in_valid && in_ready;
   assign cnt_inc = cnt_q + {{ADDR_W{1'b0}}, 1'b1};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
         sum_q   <= '0;
         error_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
`ifdef ROM_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
         error_q <= error_d;
`endif
      end
   end

   // NOTE: every combinational output gets a default first so no path
   // through the case leaves a signal unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
      error_d = error_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
`ifdef ROM_LOADER_CHECKSUM_EN
               error_d = 1'b0;
               sum_d   = '0;
`endif
               if (length == '0) begin
                  state_d = S_DONE;
               end else begin
                  len_d   = length;
                  cnt_d   = '0;
                  state_d = S_HI;
               end
            end
         end
         S_HI:    if (xfer) state_d = S_LO;
         S_LO:    if (xfer) state_d = S_WRITE;
         S_WRITE: begin
            cnt_d = cnt_inc;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_d   = sum_q + asm_word;
            state_d = (cnt_inc == len_q) ? S_CHK_HI : S_HI;
`else
            state_d = (cnt_inc == len_q) ? S_DONE : S_HI;
`endif
         end
`ifdef ROM_LOADER_CHECKSUM_EN
         S_CHK_HI: if (xfer) state_d = S_CHK_LO;
         S_CHK_LO: begin
            // The high checksum byte sits in the assembler's high register.
            if (xfer) begin
               error_d = ({asm_word[15:8], in_data} != sum_q);
               state_d = S_DONE;
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      wr_en    = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      hi_load  = 1'b0;
      lo_load  = 1'b0;
      case (state_q)
         S_IDLE:  busy = 1'b0;
         S_HI: begin
            in_ready = 1'b1;
            hi_load  = in_valid;
         end
         S_LO: begin
            in_ready = 1'b1;
            lo_load  = in_valid;
         end
         S_WRITE: wr_en = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
         S_CHK_HI: begin
            in_ready = 1'b1;
            hi_load  = in_valid;
         end
         S_CHK_LO: in_ready = 1'b1;
`endif
         S_DONE:  done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   word_assembler u_word_assembler (
      .clock   (clock),
      .reset   (reset),
      .in_data (in_data),
      .hi_load (hi_load),
      .lo_load (lo_load),
      .word    (asm_word)
   );

   assign cpu_hold   = busy;
   assign wr_address = cnt_q[ADDR_W-1:0];
   assign wr_data    = asm_word;

`ifdef ROM_LOADER_CHECKSUM_EN
   assign error = error_q;
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader; checksum cases run when
// ROM_LOADER_CHECKSUM_EN is defined for both bench and design.
module tb_rom_loader;

   localparam int ADDR_W = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W:0]   length;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] wr_address;
   logic [15:0]       wr_data;
   logic              wr_en;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              error;

   rom_loader #(.ADDR_W(ADDR_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .length     (length),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .wr_address (wr_address),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  hi;
      logic [7:0]  lo;
      logic [3:0]  exp_addr;
      logic [15:0] exp_data;
   } vec_t;

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] data;
   } wr_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   wr_t  log_q[$];
   int   done_cnt = 0;
   int   double_wr = 0;
   int   hold_mismatch = 0;
   int   hold_low = 0;
   int   ready_seen = 0;
   bit   prev_wr = 0;
   bit   active = 0;
   logic err_at_done = 1'b0;
   logic [7:0] feed [64];

   // Observer samples on the falling edge, half a cycle from the active edge.
   always @(negedge clock) begin
      if (reset) begin
         prev_wr = 0;
      end else begin
         if (wr_en) begin
            log_q.push_back('{wr_address, wr_data});
            if (prev_wr) double_wr++;
         end
         prev_wr = wr_en;
         if (done) begin
            done_cnt++;
            err_at_done = error;
         end
         if (cpu_hold !== busy) hold_mismatch++;
         if (active && !cpu_hold) hold_low++;
         if (in_ready) ready_seen++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_stats();
      log_q.delete();
      done_cnt      = 0;
      double_wr     = 0;
      hold_mismatch = 0;
      hold_low      = 0;
      ready_seen    = 0;
   endtask

   // Starts a load and streams feed[0..nbytes-1]; returns at the done pulse,
   // or early once abort_words writes were seen (abort_words > 0).
   task automatic run_load(input logic [ADDR_W:0] len, input int nbytes, input bit toggle,
                           input bit glitch, input int abort_words);
      int idx = 0;
      int cyc = 0;
      int d0  = done_cnt;
      bit aborted = 0;
      @(negedge clock); #1;
      start  = 1'b1;
      length = len;
      @(negedge clock); #1;
      start  = 1'b0;
      active = 1;
      while (done_cnt == d0 && cyc < 400) begin
         if (abort_words > 0 && log_q.size() >= abort_words) begin
            aborted = 1;
            break;
         end
         if (glitch && cyc == 5) begin
            start  = 1'b1;
            length = 5'd1;
         end else begin
            start = 1'b0;
         end
         if (idx < nbytes) begin
            in_data  = feed[idx];
            in_valid = toggle ? cyc[0] : 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         if (in_valid && in_ready) idx++;
         @(negedge clock); #1;
         cyc++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      active   = 0;
      if (!aborted) check("load_completes", (done_cnt > d0) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_wr_en"},    {31'd0, wr_en},    32'd0);
      check({tag, "_wr_addr"},  {28'd0, wr_address}, 32'd0);
      check({tag, "_wr_data"},  {16'd0, wr_data},  32'd0);
      check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
      check({tag, "_busy"},     {31'd0, busy},     32'd0);
      check({tag, "_done"},     {31'd0, done},     32'd0);
      check({tag, "_error"},    {31'd0, error},    32'd0);
   endtask

   vec_t vecs [6];

   initial begin
      vecs[0] = '{8'hEA, 8'h90, 4'd0, 16'hEA90};
      vecs[1] = '{8'hE3, 8'h20, 4'd1, 16'hE320};
      vecs[2] = '{8'hEE, 8'h88, 4'd2, 16'hEE88};
      vecs[3] = '{8'hE7, 8'hD0, 4'd3, 16'hE7D0};
      vecs[4] = '{8'h00, 8'h01, 4'd4, 16'h0001};
      vecs[5] = '{8'hEA, 8'h87, 4'd5, 16'hEA87};

      reset    = 1'b1;
      start    = 1'b0;
      length   = '0;
      in_data  = '0;
      in_valid = 1'b0;
      #1;
      check_idle_outputs("reset");
      @(negedge clock); @(negedge clock); #1;
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         feed[2*i]   = vecs[i].hi;
         feed[2*i+1] = vecs[i].lo;
      end

      // Continuous valid, then every-other-cycle valid: identical writes.
      for (int pass = 0; pass < 2; pass++) begin
         clear_stats();
         run_load(5'd6, 12, pass[0], 1'b0, 0);
         check($sformatf("p%0d_write_count", pass), log_q.size(), 32'd6);
         for (int i = 0; i < 6; i++) begin
            check($sformatf("p%0d_addr%0d", pass, i),
                  (i < log_q.size()) ? {28'd0, log_q[i].addr} : 32'hDEAD_BEEF, {28'd0, vecs[i].exp_addr});
            check($sformatf("p%0d_data%0d", pass, i),
                  (i < log_q.size()) ? {16'd0, log_q[i].data} : 32'hDEAD_BEEF, {16'd0, vecs[i].exp_data});
         end
         check($sformatf("p%0d_done_pulses", pass), done_cnt, 32'd1);
         check($sformatf("p%0d_wr_en_single", pass), double_wr, 32'd0);
         check($sformatf("p%0d_hold_low", pass), hold_low, 32'd0);
         check($sformatf("p%0d_hold_eq_busy", pass), hold_mismatch, 32'd0);
         check($sformatf("p%0d_error", pass), {31'd0, err_at_done}, 32'd0);
         @(negedge clock); #1;
         check($sformatf("p%0d_idle_after", pass), {31'd0, busy}, 32'd0);
      end

      // Zero-length load: done on the next cycle, no writes, never ready.
      clear_stats();
      in_valid = 1'b1;
      in_data  = 8'h55;
      @(negedge clock); #1;
      start  = 1'b1;
      length = 5'd0;
      @(negedge clock); #1;
      start = 1'b0;
      check("len0_done_next_cycle", {31'd0, done}, 32'd1);
      check("len0_hold_in_done", {31'd0, cpu_hold}, 32'd1);
      @(negedge clock); #1;
      check("len0_done_single", {31'd0, done}, 32'd0);
      check("len0_idle", {31'd0, busy}, 32'd0);
      @(negedge clock); #1;
      in_valid = 1'b0;
      check("len0_no_writes", log_q.size(), 32'd0);
      check("len0_never_ready", ready_seen, 32'd0);

      // Full-depth load with a stray start pulse in the middle.
      clear_stats();
      for (int i = 0; i < 16; i++) begin
         feed[2*i]   = 8'(i);
         feed[2*i+1] = 8'(8'hA0 + i);
      end
      run_load(5'd16, 32, 1'b0, 1'b1, 0);
      check("len16_write_count", log_q.size(), 32'd16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("len16_addr%0d", i),
               (i < log_q.size()) ? {28'd0, log_q[i].addr} : 32'hDEAD_BEEF, 32'(i));
         check($sformatf("len16_data%0d", i),
               (i < log_q.size()) ? {16'd0, log_q[i].data} : 32'hDEAD_BEEF, {16'd0, 8'(i), 8'(8'hA0 + i)});
      end
      check("len16_done_pulses", done_cnt, 32'd1);
      repeat (3) @(negedge clock);
      #1;
      check("len16_no_wrap_write", log_q.size(), 32'd16);

      // Reset while the third word is being written, then a fresh short load.
      clear_stats();
      for (int i = 0; i < 6; i++) begin
         feed[2*i]   = vecs[i].hi;
         feed[2*i+1] = vecs[i].lo;
      end
      run_load(5'd6, 12, 1'b0, 1'b0, 3);
      check("abort_wr_en_before", {31'd0, wr_en}, 32'd1);
      reset = 1'b1;
      #1;
      check_idle_outputs("async_reset");
      @(negedge clock); #1;
      reset = 1'b0;
      clear_stats();
      feed[0] = 8'h12; feed[1] = 8'h34; feed[2] = 8'h56; feed[3] = 8'h78;
      run_load(5'd2, 4, 1'b0, 1'b0, 0);
      check("after_reset_count", log_q.size(), 32'd2);
      check("after_reset_addr0", (log_q.size() > 0) ? {28'd0, log_q[0].addr} : 32'hDEAD_BEEF, 32'd0);
      check("after_reset_data0", (log_q.size() > 0) ? {16'd0, log_q[0].data} : 32'hDEAD_BEEF, 32'h1234);
      check("after_reset_addr1", (log_q.size() > 1) ? {28'd0, log_q[1].addr} : 32'hDEAD_BEEF, 32'd1);
      check("after_reset_data1", (log_q.size() > 1) ? {16'd0, log_q[1].data} : 32'hDEAD_BEEF, 32'h5678);

`ifdef ROM_LOADER_CHECKSUM_EN
      // Words 0x0001 + 0x0002 sum to 0x0003.
      feed[0] = 8'h00; feed[1] = 8'h01; feed[2] = 8'h00; feed[3] = 8'h02;
      feed[4] = 8'h00; feed[5] = 8'h03;
      clear_stats();
      run_load(5'd2, 6, 1'b0, 1'b0, 0);
      check("chk_good_writes", log_q.size(), 32'd2);
      check("chk_good_error", {31'd0, err_at_done}, 32'd0);
      feed[5] = 8'h04;
      clear_stats();
      run_load(5'd2, 6, 1'b1, 1'b0, 0);
      check("chk_bad_writes", log_q.size(), 32'd2);
      check("chk_bad_error_at_done", {31'd0, err_at_done}, 32'd1);
      repeat (3) @(negedge clock);
      #1;
      check("chk_bad_error_sticky", {31'd0, error}, 32'd1);
      start  = 1'b1;
      length = 5'd0;
      @(negedge clock); #1;
      start = 1'b0;
      check("chk_error_cleared", {31'd0, error}, 32'd0);
      check("chk_len0_done", {31'd0, done}, 32'd1);
      @(negedge clock); #1;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
